// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core: captures decoded operands/controls,
// inserts a one-cycle bubble on load-use hazards or branch flushes, and counts both events.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [7:0]       id_ctrl,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [7:0]       ex_ctrl,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Control vector layout: {regwrite, memread, memwrite, memtoreg, branch, alusrc, aluop[1:0]}
    localparam int CTRL_MEMREAD = 6;

    logic hazard;
    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
        // Loads into x0 never produce a value worth waiting for.
        hazard    = id_valid && ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rd != 5'd0)
                    && (rs1_match || rs2_match);
    end

    // A flush discards the dependent instruction anyway, so it overrides the interlock.
    assign pc_write    = !(hazard && !flush);
    assign if_id_write = pc_write;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else if (flush) begin
            // Bubble: only valid and ctrl are cleared; the payload is left holding since
            // a zero ctrl already makes it invisible downstream.
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            flush_cnt <= sat_inc(flush_cnt);
        end else if (hazard) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            stall_cnt <= sat_inc(stall_cnt);
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_valid ? id_ctrl : 8'h00;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a directed vector table walked cycle by cycle, plus
// hand sequences for reset, reset during a stall, and counter saturation.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int CNT_W = 16;
    localparam int SAT_W = 3;

    localparam logic [7:0] C_LW   = 8'hD4;  // regwrite memread memtoreg alusrc
    localparam logic [7:0] C_ADD  = 8'h82;  // regwrite aluop=10
    localparam logic [7:0] C_ADDI = 8'h86;  // regwrite alusrc aluop=10
    localparam logic [7:0] C_SW   = 8'h24;  // memwrite alusrc

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2;
    logic [7:0]      id_ctrl;
    logic            flush;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [7:0]       ex_ctrl;
    logic             pc_write, if_id_write;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic             s_ex_valid;
    logic [XLEN-1:0]  s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [4:0]       s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [7:0]       s_ex_ctrl;
    logic             s_pc_write, s_if_id_write;
    logic [SAT_W-1:0] s_stall_cnt, s_flush_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, so saturation is reachable quickly.
    id_ex_stage #(.XLEN(XLEN), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl), .flush(flush),
        .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1_data(s_ex_rs1_data),
        .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
        .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2;
        logic [7:0]  ctrl;
        logic        flsh;
        logic [31:0] pc;
        logic        e_pcw;
        logic        e_valid;
        logic [7:0]  e_ctrl;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [31:0] e_pc;
        logic [15:0] e_stall, e_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string name, input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rd, input logic use1, input logic use2, input logic [7:0] ctrl,
        input logic flsh, input logic [31:0] pc, input logic e_pcw, input logic e_valid,
        input logic [7:0] e_ctrl, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
        input logic [4:0] e_rd, input logic [31:0] e_pc, input logic [15:0] e_stall,
        input logic [15:0] e_flush);
        vec_t v;
        v.name = name; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.use1 = use1; v.use2 = use2; v.ctrl = ctrl; v.flsh = flsh; v.pc = pc;
        v.e_pcw = e_pcw; v.e_valid = e_valid; v.e_ctrl = e_ctrl; v.e_rs1 = e_rs1;
        v.e_rs2 = e_rs2; v.e_rd = e_rd; v.e_pc = e_pc; v.e_stall = e_stall;
        v.e_flush = e_flush;
        return v;
    endfunction

    // Operand data is tied to the PC so held payloads can be checked without extra columns.
    function automatic logic [31:0] dat(input logic [3:0] tag, input logic [31:0] pc);
        return {tag, 12'h000, pc[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic use1, input logic use2,
                         input logic [7:0] ctrl, input logic flsh, input logic [31:0] pc);
        id_valid    = valid;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_use_rs1  = use1;
        id_use_rs2  = use2;
        id_ctrl     = ctrl;
        flush       = flsh;
        id_pc       = pc;
        id_rs1_data = dat(4'hA, pc);
        id_rs2_data = dat(4'hB, pc);
        id_imm      = dat(4'hC, pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        vecs.push_back(mk("lw_x5_a",          1,1,0,5,1,0,C_LW,  0,32'h100, 1,1,C_LW,  1,0,5,32'h100,0,0));
        vecs.push_back(mk("add_uses_x5",      1,5,7,6,1,1,C_ADD, 0,32'h104, 0,0,8'h00, 1,0,5,32'h100,1,0));
        vecs.push_back(mk("add_released",     1,5,7,6,1,1,C_ADD, 0,32'h104, 1,1,C_ADD, 5,7,6,32'h104,1,0));
        vecs.push_back(mk("lw_x0",            1,2,0,0,1,0,C_LW,  0,32'h108, 1,1,C_LW,  2,0,0,32'h108,1,0));
        vecs.push_back(mk("add_reads_x0",     1,0,0,7,1,1,C_ADD, 0,32'h10C, 1,1,C_ADD, 0,0,7,32'h10C,1,0));
        vecs.push_back(mk("lw_x5_b",          1,3,0,5,1,0,C_LW,  0,32'h110, 1,1,C_LW,  3,0,5,32'h110,1,0));
        vecs.push_back(mk("addi_rs2_unused",  1,8,5,6,1,0,C_ADDI,0,32'h114, 1,1,C_ADDI,8,5,6,32'h114,1,0));
        vecs.push_back(mk("lw_x5_c",          1,4,0,5,1,0,C_LW,  0,32'h118, 1,1,C_LW,  4,0,5,32'h118,1,0));
        vecs.push_back(mk("id_invalid_match", 0,5,0,9,1,0,C_ADD, 0,32'h11C, 1,0,8'h00, 5,0,9,32'h11C,1,0));
        vecs.push_back(mk("lw_x5_d",          1,1,0,5,1,0,C_LW,  0,32'h120, 1,1,C_LW,  1,0,5,32'h120,1,0));
        vecs.push_back(mk("sw_uses_x5_rs2",   1,2,5,0,1,1,C_SW,  0,32'h124, 0,0,8'h00, 1,0,5,32'h120,2,0));
        vecs.push_back(mk("sw_released",      1,2,5,0,1,1,C_SW,  0,32'h124, 1,1,C_SW,  2,5,0,32'h124,2,0));
        vecs.push_back(mk("lw_x5_e",          1,1,0,5,1,0,C_LW,  0,32'h128, 1,1,C_LW,  1,0,5,32'h128,2,0));
        vecs.push_back(mk("flush_over_hazard",1,5,7,6,1,1,C_ADD, 1,32'h12C, 1,0,8'h00, 1,0,5,32'h128,2,1));
        vecs.push_back(mk("flush_alone",      1,6,7,7,1,1,C_ADD, 1,32'h130, 1,0,8'h00, 1,0,5,32'h128,2,2));
        vecs.push_back(mk("resume",           1,6,7,7,1,1,C_ADD, 0,32'h130, 1,1,C_ADD, 6,7,7,32'h130,2,2));

        // Reset held for two clocks.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.ex_valid",  64'(ex_valid), 64'(1'b0));
        check("reset.ex_ctrl",   64'(ex_ctrl), 64'(8'h00));
        check("reset.ex_pc",     64'(ex_pc), 64'(32'h0));
        check("reset.stall_cnt", 64'(stall_cnt), 64'(16'h0));
        check("reset.flush_cnt", 64'(flush_cnt), 64'(16'h0));
        check("reset.pc_write",  64'(pc_write), 64'(1'b1));
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            drive(v.valid, v.rs1, v.rs2, v.rd, v.use1, v.use2, v.ctrl, v.flsh, v.pc);
            #1;
            check({v.name, ".pc_write"},    64'(pc_write), 64'(v.e_pcw));
            check({v.name, ".if_id_write"}, 64'(if_id_write), 64'(v.e_pcw));
            @(posedge clk);
            #1;
            check({v.name, ".ex_valid"},    64'(ex_valid), 64'(v.e_valid));
            check({v.name, ".ex_ctrl"},     64'(ex_ctrl), 64'(v.e_ctrl));
            check({v.name, ".ex_rs1"},      64'(ex_rs1), 64'(v.e_rs1));
            check({v.name, ".ex_rs2"},      64'(ex_rs2), 64'(v.e_rs2));
            check({v.name, ".ex_rd"},       64'(ex_rd), 64'(v.e_rd));
            check({v.name, ".ex_pc"},       64'(ex_pc), 64'(v.e_pc));
            check({v.name, ".ex_rs1_data"}, 64'(ex_rs1_data), 64'(dat(4'hA, v.e_pc)));
            check({v.name, ".ex_rs2_data"}, 64'(ex_rs2_data), 64'(dat(4'hB, v.e_pc)));
            check({v.name, ".ex_imm"},      64'(ex_imm), 64'(dat(4'hC, v.e_pc)));
            check({v.name, ".stall_cnt"},   64'(stall_cnt), 64'(v.e_stall));
            check({v.name, ".flush_cnt"},   64'(flush_cnt), 64'(v.e_flush));
        end

        // Reset arriving while a load-use stall is being requested.
        @(negedge clk);
        drive(1, 1, 0, 5, 1, 0, C_LW, 0, 32'h200);
        @(negedge clk);
        drive(1, 5, 7, 6, 1, 1, C_ADD, 0, 32'h204);
        #1;
        check("rst_stall.pc_write_before", 64'(pc_write), 64'(1'b0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_stall.ex_valid",  64'(ex_valid), 64'(1'b0));
        check("rst_stall.ex_ctrl",   64'(ex_ctrl), 64'(8'h00));
        check("rst_stall.pc_write",  64'(pc_write), 64'(1'b1));
        check("rst_stall.stall_cnt", 64'(stall_cnt), 64'(16'h0));
        check("rst_stall.flush_cnt", 64'(flush_cnt), 64'(16'h0));
        @(negedge clk);
        reset = 1'b0;

        // Nine load-use stalls: the wide counter tracks exactly, the narrow one pins at 7.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            drive(1, 1, 0, 5, 1, 0, C_LW, 0, 32'h300);
            @(negedge clk);
            drive(1, 5, 0, 6, 1, 0, C_ADD, 0, 32'h304);
            #1;
            check($sformatf("sat_stall%0d.pc_write", i), 64'(s_pc_write), 64'(1'b0));
            @(posedge clk);
            #1;
            check($sformatf("sat_stall%0d.wide", i), 64'(stall_cnt), 64'(i));
            check($sformatf("sat_stall%0d.narrow", i), 64'(s_stall_cnt), 64'((i > 7) ? 7 : i));
        end

        // Nine flushes: the narrow flush counter also pins at 7.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            drive(1, 2, 3, 4, 1, 1, C_ADD, 1, 32'h400);
            @(posedge clk);
            #1;
            check($sformatf("sat_flush%0d.wide", i), 64'(flush_cnt), 64'(i));
            check($sformatf("sat_flush%0d.narrow", i), 64'(s_flush_cnt), 64'((i > 7) ? 7 : i));
            check($sformatf("sat_flush%0d.stall_hold", i), 64'(s_stall_cnt), 64'(7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
